// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: state encoding and counter widths.
// Used by pipe_stall_ctrl and pipe_sat_cnt (stats counters built only with PIPE_STALL_STATS_EN).
package pipe_ctrl_pkg;

  localparam int CNT_W  = 8;
  localparam int STAT_W = 16;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [STAT_W-1:0] stat_t;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_LSTALL = 3'd1,
    ST_MDWAIT = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones once full.
module pipe_sat_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  output stat_t count
);

  stat_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: single owner of PC/IF-ID enables, IF-ID flush, ID-EX bubble and EX hold.
// Optional stall/flush statistics ports are added when PIPE_STALL_STATS_EN is defined.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int MD_TIMEOUT = 32,
  parameter int DRAIN_CYC  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        md_done,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        if_write,
  output logic        if_flush,
  output logic        id_bubble,
  output logic        ex_hold,
  output logic        halted,
  output logic        md_timeout,
  output logic [2:0]  state
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);

  localparam cnt_t LS_RELOAD    = cnt_t'((LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0);
  localparam cnt_t DRAIN_RELOAD = cnt_t'(DRAIN_CYC - 1);
  localparam cnt_t MD_LAST      = cnt_t'(MD_TIMEOUT - 1);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   md_to_q, md_to_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_to_d   = md_to_q;
    pc_write  = 1'b0;
    if_write  = 1'b0;
    if_flush  = 1'b0;
    id_bubble = 1'b0;
    ex_hold   = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_RUN: begin
        pc_write = 1'b1;
        if_write = 1'b1;
        if (halt_req) begin
          pc_write = 1'b0;
          if_write = 1'b0;
          if_flush = 1'b1;
          state_d  = ST_DRAIN;
          cnt_d    = DRAIN_RELOAD;
        end else if (md_start) begin
          pc_write = 1'b0;
          if_write = 1'b0;
          ex_hold  = 1'b1;
          state_d  = ST_MDWAIT;
          cnt_d    = '0;
        end else if (load_use) begin
          // A same-cycle branch is dropped; the hazard unit re-presents it after the stall.
          pc_write  = 1'b0;
          if_write  = 1'b0;
          id_bubble = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = ST_LSTALL;
            cnt_d   = LS_RELOAD;
          end
        end else if (branch_taken) begin
          if_flush = 1'b1;
        end
      end
      ST_LSTALL: begin
        id_bubble = 1'b1;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_MDWAIT: begin
        if (md_done) begin
          state_d = ST_RUN;
        end else begin
          ex_hold = 1'b1;
          if (cnt_q == MD_LAST) begin
            md_to_d = 1'b1;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        id_bubble = 1'b1;
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HALTED: begin
        halted    = 1'b1;
        id_bubble = 1'b1;
        if (!halt_req) state_d = ST_RUN;
      end
      default: begin
        id_bubble = 1'b1;
        state_d   = ST_RUN;
        cnt_d     = '0;
      end
    endcase

    // Reset overrides the decode so the pipe sees a bubble and no writes while rst_n is low.
    if (!rst_n) begin
      pc_write  = 1'b0;
      if_write  = 1'b0;
      if_flush  = 1'b0;
      id_bubble = 1'b1;
      ex_hold   = 1'b0;
      halted    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      md_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_to_q <= md_to_d;
    end
  end

  assign md_timeout = md_to_q;
  assign state      = state_q;

`ifdef PIPE_STALL_STATS_EN
  pipe_sat_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!pc_write && (state_q != ST_HALTED)),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  pipe_sat_cnt u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if_flush),
    .clr   (1'b0),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (LOAD_STALL=2 and 1) share stimulus and are
// compared every cycle against a cycle-count reference model. Honours PIPE_STALL_STATS_EN.
module tb_pipe_stall_ctrl;

  localparam int MDT   = 32;
  localparam int DRAIN = 3;

  typedef struct packed {
    logic       pc;
    logic       ifw;
    logic       flush;
    logic       bub;
    logic       hold;
    logic       halted;
    logic       to;
    logic [2:0] st;
  } obs_t;

  // mode: 0 run, 1 load stall, 2 mul/div wait, 3 drain, 4 halted
  typedef struct {
    int mode;
    int left;
    int elapsed;
    bit to;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n, load_use, branch_taken, md_start, md_done, halt_req;

  logic a_pc, a_ifw, a_flush, a_bub, a_hold, a_halted, a_to;
  logic b_pc, b_ifw, b_flush, b_bub, b_hold, b_halted, b_to;
  logic [2:0] a_state, b_state;
`ifdef PIPE_STALL_STATS_EN
  logic [15:0] a_stall, a_fl, b_stall, b_fl;
  int sa, fa, sb, fb;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  mdl_t ma, mb;
  obs_t reset_vec;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.LOAD_STALL(2), .MD_TIMEOUT(MDT), .DRAIN_CYC(DRAIN)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
    .md_start(md_start), .md_done(md_done), .halt_req(halt_req),
    .pc_write(a_pc), .if_write(a_ifw), .if_flush(a_flush), .id_bubble(a_bub),
    .ex_hold(a_hold), .halted(a_halted), .md_timeout(a_to), .state(a_state)
`ifdef PIPE_STALL_STATS_EN
    , .stall_cnt(a_stall), .flush_cnt(a_fl)
`endif
  );

  pipe_stall_ctrl #(.LOAD_STALL(1), .MD_TIMEOUT(MDT), .DRAIN_CYC(DRAIN)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
    .md_start(md_start), .md_done(md_done), .halt_req(halt_req),
    .pc_write(b_pc), .if_write(b_ifw), .if_flush(b_flush), .id_bubble(b_bub),
    .ex_hold(b_hold), .halted(b_halted), .md_timeout(b_to), .state(b_state)
`ifdef PIPE_STALL_STATS_EN
    , .stall_cnt(b_stall), .flush_cnt(b_fl)
`endif
  );

  wire obs_t obs_a = {a_pc, a_ifw, a_flush, a_bub, a_hold, a_halted, a_to, a_state};
  wire obs_t obs_b = {b_pc, b_ifw, b_flush, b_bub, b_hold, b_halted, b_to, b_state};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s@%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: outputs for the current cycle and the situation one cycle later.
  function automatic void model_step(input mdl_t m, input int ls, input bit hr, ms, md, lu, bt,
                                     output obs_t o, output mdl_t n);
    n    = m;
    o    = '0;
    o.st = 3'(m.mode);
    o.to = m.to;
    case (m.mode)
      0: begin
        if (hr) begin
          o.flush = 1'b1; n.mode = 3; n.left = DRAIN;
        end else if (ms) begin
          o.hold = 1'b1; n.mode = 2; n.elapsed = 1;
        end else if (lu) begin
          o.bub = 1'b1;
          if (ls > 1) begin n.mode = 1; n.left = ls - 1; end
        end else begin
          o.pc = 1'b1; o.ifw = 1'b1; o.flush = bt;
        end
      end
      1: begin
        o.bub = 1'b1; n.left = m.left - 1;
        if (n.left == 0) n.mode = 0;
      end
      2: begin
        if (md) n.mode = 0;
        else begin
          o.hold = 1'b1;
          if (m.elapsed == MDT) begin n.to = 1'b1; n.mode = 0; end
          else n.elapsed = m.elapsed + 1;
        end
      end
      3: begin
        o.bub = 1'b1; n.left = m.left - 1;
        if (n.left == 0) n.mode = 4;
      end
      default: begin
        o.halted = 1'b1; o.bub = 1'b1;
        if (!hr) n.mode = 0;
      end
    endcase
  endfunction

  task automatic model_reset();
    ma = '{0, 0, 0, 1'b0};
    mb = '{0, 0, 0, 1'b0};
`ifdef PIPE_STALL_STATS_EN
    sa = 0; fa = 0; sb = 0; fb = 0;
`endif
  endtask

  // Apply one cycle of inputs just after a rising edge, check, then advance to the next edge.
  task automatic cycle(input bit hr, ms, md, lu, bt);
    obs_t oa, ob;
    mdl_t na, nb;
    halt_req = hr; md_start = ms; md_done = md; load_use = lu; branch_taken = bt;
    #1;
    model_step(ma, 2, hr, ms, md, lu, bt, oa, na);
    model_step(mb, 1, hr, ms, md, lu, bt, ob, nb);
    check("a", 32'(obs_a), 32'(oa));
    check("b", 32'(obs_b), 32'(ob));
`ifdef PIPE_STALL_STATS_EN
    check("a_stats", {a_stall, a_fl}, {16'(sa), 16'(fa)});
    check("b_stats", {b_stall, b_fl}, {16'(sb), 16'(fb)});
    if (!oa.pc && ma.mode != 4) sa = (sa < 65535) ? sa + 1 : sa;
    if (!ob.pc && mb.mode != 4) sb = (sb < 65535) ? sb + 1 : sb;
    if (oa.flush) fa = (fa < 65535) ? fa + 1 : fa;
    if (ob.flush) fb = (fb < 65535) ? fb + 1 : fb;
`endif
    @(posedge clk);
    ma = na;
    mb = nb;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit hr_lvl;
    reset_vec = '{pc: 1'b0, ifw: 1'b0, flush: 1'b0, bub: 1'b1, hold: 1'b0,
                  halted: 1'b0, to: 1'b0, st: 3'd0};
    rst_n = 1'b0;
    halt_req = 0; md_start = 0; md_done = 0; load_use = 0; branch_taken = 0;
    model_reset();

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_a", 32'(obs_a), 32'(reset_vec));
      check("rst_b", 32'(obs_b), 32'(reset_vec));
    end
    rst_n = 1'b1;
    idle(2);

    // Load-use stall: two bubbles on dut_a, one on dut_b.
    cycle(0, 0, 0, 1, 0);
    idle(3);

    // Load-use with a branch in the same cycle, branch re-presented afterwards.
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    idle(2);

    // Mul/div completes after five hold cycles.
    cycle(0, 1, 0, 0, 0);
    idle(4);
    cycle(0, 0, 1, 0, 0);
    idle(2);

    // Mul/div never completes: forced return after MDT cycles, sticky timeout flag.
    cycle(0, 1, 0, 0, 0);
    idle(MDT + 4);

    // Halt wins over a same-cycle mul/div start; drain, halt, then resume.
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < DRAIN + 3; i++) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    idle(2);

    // Asynchronous reset in the middle of a mul/div wait.
    cycle(0, 1, 0, 0, 0);
    idle(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_a", 32'(obs_a), 32'(reset_vec));
    check("arst_b", 32'(obs_b), 32'(reset_vec));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic with a slowly toggling halt level.
    hr_lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) hr_lvl = ~hr_lvl;
      cycle(hr_lvl,
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0));
    end
    cycle(0, 0, 0, 0, 0);
    idle(DRAIN + 2);

`ifdef PIPE_STALL_STATS_EN
    // Continuous branches drive flush_cnt into saturation.
    for (int i = 0; i < 65560; i++) cycle(0, 0, 0, 0, 1);
    check("a_fl_sat", 32'(a_fl), 32'hFFFF);
    check("b_fl_sat", 32'(b_fl), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
